apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, maximum ACCESS-phase cycles without pready before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  per-requester transfer request; bit i belongs to requester i.
REQ-006 req_write  input  2  per-requester direction; 1 = write.
REQ-007 req_addr  input  64  packed addresses; requester i uses bits [32i+31:32i].
REQ-008 req_wdata  input  64  packed write data, packed the same way as req_addr.
REQ-009 req_grant  output  2  one-hot, one-cycle pulse when the request is accepted and latched.
REQ-010 rsp_valid  output  2  one-hot, one-cycle pulse when the transfer completes.
REQ-011 rsp_rdata  output  32  read data; valid while rsp_valid is nonzero.
REQ-012 rsp_err  output  1  timeout flag; valid while rsp_valid is nonzero.
REQ-013 psel, penable, pwrite  output  1 each  APB control to the slave.
REQ-014 paddr, pwdata  output  32 each  APB address and write data.
REQ-015 prdata  input  32  APB read data; pready  input  1  APB slave ready.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-017 IDLE, any req_valid high: arbitrate, latch the winner's addr/write/wdata into paddr/pwrite/pwdata, pulse req_grant[winner] on the next cycle and go to SETUP.
REQ-018 IDLE, no req_valid: psel=0 and penable=0; paddr/pwrite/pwdata hold their last values.
REQ-019 SETUP SHALL last exactly one cycle (psel=1, penable=0), then go to ACCESS.
REQ-020 ACCESS: psel=1 and penable=1, held until pready is sampled high.
REQ-021 On pready in ACCESS: capture prdata (reads) or 0 (writes) into rsp_rdata, pulse rsp_valid[owner] with rsp_err=0 on the next cycle, and return to IDLE.
REQ-022 Zero-wait latency: req_valid at cycle T -> req_grant and SETUP at T+1 -> ACCESS at T+2 -> rsp_valid at T+3.
REQ-023 Arbitration SHALL be round-robin: with both requesters valid, the one not granted last wins; with one valid, it wins.
REQ-024 After reset the round-robin pointer SHALL favour requester 0.
REQ-025 A requester SHALL hold its req fields stable until its grant; the block ignores req_valid changes during SETUP and ACCESS.
REQ-026 IDLE SHALL last at least one cycle between transfers, so psel drops between back-to-back transfers.
REQ-027 The block SHALL never issue more than one outstanding transfer.
REQ-028 req_grant and rsp_valid SHALL never pulse for a requester whose request was not latched.

Reset
REQ-029 rst high SHALL force, on the next edge: state=IDLE; psel, penable, pwrite=0; paddr, pwdata, rsp_rdata=0; req_grant, rsp_valid=0; rsp_err=0; round-robin pointer favours requester 0; timeout counter=0.
REQ-030 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse.

Configuration
REQ-031 The ACCESS-phase timeout SHALL be compiled in only when macro APB_ARB_TIMEOUT_EN is defined.
REQ-032 With APB_ARB_TIMEOUT_EN: count ACCESS cycles; if TIMEOUT_CYC cycles pass without pready, drop psel/penable, pulse rsp_valid[owner] with rsp_err=1 and rsp_rdata=0, and go to IDLE.
REQ-033 With APB_ARB_TIMEOUT_EN: pready in the same cycle the count expires SHALL win, giving a normal completion.
REQ-034 Without APB_ARB_TIMEOUT_EN: ACCESS waits indefinitely, rsp_err is tied to 0, and no counter logic exists.

Structure
REQ-035 Shared package apb_pkg SHALL hold the IDLE/SETUP/ACCESS state enum typedef, the APB address/data width constants (32) and the requester-count constant (2).
REQ-036 Round-robin selection SHALL be one sub-module, apb_rr_arbiter: request vector and update strobe in, one-hot grant out, internal last-grant pointer.

Verification
REQ-037 Single write: req0 write addr 0x10 data 0xDEADBEEF, pready=1 -> grant[0] at T+1, psel at T+1, penable at T+2, rsp_valid[0] at T+3, rsp_err=0.
REQ-038 Read with wait states: req1 read addr 0x14, pready held low 3 cycles, prdata=0x5 -> ACCESS held 4 cycles, rsp_rdata=0x5 with rsp_valid[1].
REQ-039 Contention: both requesters valid continuously for 4 transfers -> grant order 0,1,0,1, with psel low one cycle between transfers.
REQ-040 Reset mid-ACCESS: rst asserted for one cycle during ACCESS -> all outputs 0 next cycle, no rsp_valid; next request granted to requester 0.
REQ-041 Timeout (macro defined, TIMEOUT_CYC=16): pready never asserted -> rsp_valid pulse with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles.
REQ-042 No timeout (macro undefined): pready stays low for 100 cycles -> still in ACCESS, no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB arbitrating master:
// FSM state encoding, bus widths, requester count and a one-hot helper.
package apb_pkg;

  localparam int APB_AW  = 32;
  localparam int APB_DW  = 32;
  localparam int NUM_REQ = 2;
  localparam int REQ_IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Index of the set bit of a one-hot requester vector (0 when empty).
  function automatic logic [REQ_IW-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = REQ_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus between the arbitrating master and a single slave.
//
// Handshake: the master raises psel with penable low for exactly one SETUP
// cycle, then raises penable; paddr/pwrite/pwdata are stable for the whole
// transfer. The transfer completes on the first rising edge where psel,
// penable and pready are all high; prdata is only meaningful at that edge
// for reads. psel drops for at least one cycle between transfers.
interface apb_arb_master_if;
  import apb_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [APB_DW-1:0] pwdata;
  logic [APB_DW-1:0] prdata;
  logic              pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// rotating priority starting just after the last requester served. The
// pointer only moves when the caller strobes update (i.e. a grant is taken).
module apb_rr_arbiter
  import apb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant
);

  logic [REQ_IW-1:0] last_idx;
  logic [REQ_IW-1:0] idx;
  logic              found;

  // Pick the first requester after last_idx, wrapping around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = REQ_IW'((int'(last_idx) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Remember the last winner; reset points at the highest index so that
  // requester 0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx <= REQ_IW'(NUM_REQ - 1);
    end else if (update && (|grant)) begin
      last_idx <= onehot_to_idx(grant);
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration in IDLE, one APB
// transfer at a time (IDLE -> SETUP -> ACCESS -> IDLE), one-cycle grant and
// response pulses back to the owning requester.
// Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*APB_AW-1:0] req_addr,
  input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [APB_DW-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output apb_state_e                state_dbg,
  apb_arb_master_if.master          apb
);

  apb_state_e         state, state_n;
  logic               arb_update;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] owner;
  logic [APB_AW-1:0]  sel_addr, paddr_q;
  logic [APB_DW-1:0]  sel_wdata, pwdata_q;
  logic               sel_write, pwrite_q;
  logic               start;
  logic               done_ok;

  apb_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (arb_update),
    .grant  (arb_grant)
  );

  assign start   = (state == IDLE) && (|req_valid);
  assign done_ok = (state == ACCESS) && apb.pready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Abort on the last allowed ACCESS cycle only if pready is still low,
  // so a late pready always wins over the timeout.
  assign tmo_hit = (state == ACCESS) && !apb.pready &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Count cycles spent in ACCESS; cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rst || (state != ACCESS)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Error flag travels with the response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= tmo_hit;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Mux the winning requester's fields out of the packed request buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = req_addr[i*APB_AW +: APB_AW];
        sel_wdata = req_wdata[i*APB_DW +: APB_DW];
        sel_write = req_write[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; request inputs are only looked at in IDLE.
  always_comb begin
    state_n    = state;
    arb_update = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SETUP;
          arb_update = 1'b1;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (done_ok) begin
          state_n = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch the granted request, pulse grant/response and capture read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      owner     <= '0;
      req_grant <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      req_grant <= '0;
      rsp_valid <= '0;
      if (start) begin
        paddr_q   <= sel_addr;
        pwdata_q  <= sel_wdata;
        pwrite_q  <= sel_write;
        owner     <= arb_grant;
        req_grant <= arb_grant;
      end
      if (done_ok) begin
        rsp_valid <= owner;
        rsp_rdata <= pwrite_q ? '0 : apb.prdata;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (tmo_hit) begin
        rsp_valid <= owner;
        rsp_rdata <= '0;
      end
`endif
    end
  end

  assign apb.psel    = (state != IDLE);
  assign apb.penable = (state == ACCESS);
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: reset, single write, read with wait
// states, round-robin contention, reset mid-ACCESS, and the ACCESS-phase
// timeout (or its absence, depending on APB_ARB_TIMEOUT_EN).
module tb_apb_arb_master;
  import apb_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*APB_AW-1:0] req_addr  = '0;
  logic [NUM_REQ*APB_DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [APB_DW-1:0]         rsp_rdata;
  logic                      rsp_err;
  apb_state_e                state_dbg;

  apb_arb_master_if bus ();

  apb_arb_master #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_grant (req_grant),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .state_dbg (state_dbg),
    .apb       (bus)
  );

  // Scoreboard
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"},     32'(state_dbg), 32'(IDLE));
    check({tag, " psel"},      32'(bus.psel), 32'd0);
    check({tag, " penable"},   32'(bus.penable), 32'd0);
    check({tag, " pwrite"},    32'(bus.pwrite), 32'd0);
    check({tag, " paddr"},     bus.paddr, 32'd0);
    check({tag, " pwdata"},    bus.pwdata, 32'd0);
    check({tag, " req_grant"}, 32'(req_grant), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, " rsp_err"},   32'(rsp_err), 32'd0);
  endtask

  initial begin
    logic [1:0] e;
    bus.prdata = '0;
    bus.pready = 1'b0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single write, zero wait states
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h10};
    req_wdata = {32'h0, 32'hDEADBEEF};
    bus.pready = 1'b1;
    tick();
    check("wr grant",   32'(req_grant), 32'h1);
    check("wr psel",    32'(bus.psel), 32'd1);
    check("wr setup penable", 32'(bus.penable), 32'd0);
    check("wr paddr",   bus.paddr, 32'h10);
    check("wr pwrite",  32'(bus.pwrite), 32'd1);
    check("wr pwdata",  bus.pwdata, 32'hDEADBEEF);
    req_valid = 2'b00;
    tick();
    check("wr access penable", 32'(bus.penable), 32'd1);
    check("wr access psel",    32'(bus.psel), 32'd1);
    check("wr grant pulse",    32'(req_grant), 32'd0);
    check("wr no early rsp",   32'(rsp_valid), 32'd0);
    tick();
    check("wr rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr rsp_err",   32'(rsp_err), 32'd0);
    check("wr rsp_rdata", rsp_rdata, 32'd0);
    check("wr idle psel", 32'(bus.psel), 32'd0);
    tick();
    check("wr rsp pulse", 32'(rsp_valid), 32'd0);

    // Read from requester 1 with three wait states
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr  = {32'h14, 32'h0};
    bus.pready = 1'b0;
    tick();
    check("rd grant", 32'(req_grant), 32'h2);
    check("rd paddr", bus.paddr, 32'h14);
    check("rd pwrite", 32'(bus.pwrite), 32'd0);
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rd wait penable", 32'(bus.penable), 32'd1);
      check("rd wait no rsp",  32'(rsp_valid), 32'd0);
    end
    tick();
    check("rd 4th access penable", 32'(bus.penable), 32'd1);
    bus.pready = 1'b1;
    bus.prdata = 32'h5;
    tick();
    check("rd rsp_valid", 32'(rsp_valid), 32'h2);
    check("rd rsp_rdata", rsp_rdata, 32'h5);
    check("rd rsp_err",   32'(rsp_err), 32'd0);

    // Contention: both requesters valid for four transfers
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {32'h200, 32'h100};
    bus.prdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      tick();
      check("rr grant",   32'(req_grant), 32'(e));
      check("rr psel",    32'(bus.psel), 32'd1);
      check("rr paddr",   bus.paddr, (e == 2'b01) ? 32'h100 : 32'h200);
      tick();
      check("rr penable", 32'(bus.penable), 32'd1);
      tick();
      check("rr psel gap", 32'(bus.psel), 32'd0);
      check("rr rsp_valid", 32'(rsp_valid), 32'(e));
      check("rr rsp_rdata", rsp_rdata, 32'h77);
    end
    req_valid = 2'b00;

    // Reset mid-ACCESS: pointer moves to favour requester 1, then reset
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h20};
    req_wdata = {32'h0, 32'h1234};
    bus.pready = 1'b0;
    tick();
    check("rst grant", 32'(req_grant), 32'h1);
    req_valid = 2'b00;
    tick();
    check("rst in access", 32'(state_dbg), 32'(ACCESS));
    rst = 1'b1;
    tick();
    check_all_zero("mid rst");
    rst = 1'b0;
    tick();
    check("post rst no rsp", 32'(rsp_valid), 32'd0);
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {32'h44, 32'h40};
    tick();
    check("post rst grant", 32'(req_grant), 32'h1);
    check("post rst paddr", bus.paddr, 32'h40);
    req_valid = 2'b00;
    bus.pready = 1'b1;
    bus.prdata = 32'hA5;
    tick();
    tick();
    check("post rst rsp", 32'(rsp_valid), 32'h1);
    check("post rst rdata", rsp_rdata, 32'hA5);

    // ACCESS with pready held low
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr  = {32'h80, 32'h0};
    bus.pready = 1'b0;
    bus.prdata = 32'hFFFF;
    tick();
    check("tmo grant", 32'(req_grant), 32'h2);
    req_valid = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      tick();
      check("tmo access", 32'(bus.penable), 32'd1);
      check("tmo no rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("tmo rsp_valid", 32'(rsp_valid), 32'h2);
    check("tmo rsp_err",   32'(rsp_err), 32'd1);
    check("tmo rsp_rdata", rsp_rdata, 32'd0);
    check("tmo psel",      32'(bus.psel), 32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      check("hold access", 32'(bus.penable), 32'd1);
      check("hold no rsp", 32'(rsp_valid), 32'd0);
    end
    bus.pready = 1'b1;
    tick();
    check("hold rsp_valid", 32'(rsp_valid), 32'h2);
    check("hold rsp_err",   32'(rsp_err), 32'd0);
    check("hold rsp_rdata", rsp_rdata, 32'hFFFF);
`endif

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
